// File: rtl/rab_inv_engine_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rab_inv_engine_if
// Brief    : Request, L1 slice, L2 read/clear and status bundle of the
//            RAB invalidation engine.
// Revision : 1.0 - initial release
// ============================================================================
interface rab_inv_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int N_SLICES   = 16,
    parameter int IW         = 10,
    parameter int PAGE_SHIFT = 12
);
    logic                             inv_req_i;
    logic                             inv_ready_o;
    logic [ADDR_WIDTH-1:0]            inv_start_i;
    logic [ADDR_WIDTH-1:0]            inv_end_i;
    logic [N_SLICES*ADDR_WIDTH-1:0]   l1_start_i;
    logic [N_SLICES*ADDR_WIDTH-1:0]   l1_end_i;
    logic [N_SLICES-1:0]              l1_en_i;
    logic [N_SLICES-1:0]              l1_clr_o;
    logic                             l2_rd_en_o;
    logic [IW-1:0]                    l2_rd_addr_o;
    logic [ADDR_WIDTH-PAGE_SHIFT-1:0] l2_rd_vpn_i;
    logic                             l2_rd_valid_i;
    logic                             l2_clr_o;
    logic [IW-1:0]                    l2_clr_addr_o;
    logic                             busy_o;
    logic                             done_o;
    logic [15:0]                      clr_cnt_o;

    modport master (
        output inv_req_i, inv_start_i, inv_end_i, l1_start_i, l1_end_i, l1_en_i,
               l2_rd_vpn_i, l2_rd_valid_i,
        input  inv_ready_o, l1_clr_o, l2_rd_en_o, l2_rd_addr_o, l2_clr_o,
               l2_clr_addr_o, busy_o, done_o, clr_cnt_o
    );

    modport slave (
        input  inv_req_i, inv_start_i, inv_end_i, l1_start_i, l1_end_i, l1_en_i,
               l2_rd_vpn_i, l2_rd_valid_i,
        output inv_ready_o, l1_clr_o, l2_rd_en_o, l2_rd_addr_o, l2_clr_o,
               l2_clr_addr_o, busy_o, done_o, clr_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/rab_inv_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rab_inv_engine
// Brief    : Range invalidation sweep over L1 slices and the L2 TLB array.
// Revision : 1.0 - initial release
// ============================================================================
module rab_inv_engine #(
    parameter int ADDR_WIDTH       = 32,
    parameter int N_SLICES         = 16,
    parameter int N_L2_SETS        = 32,
    parameter int N_L2_SET_ENTRIES = 32,
    parameter int EN_L2            = 1,
    parameter int PAGE_SHIFT       = 12
) (
    input  logic               Clk_CI,
    input  logic               Rst_RBI,
    rab_inv_engine_if.slave    bus
);
    localparam int c_NE    = N_L2_SETS * N_L2_SET_ENTRIES;
    localparam int c_IW    = (c_NE > 1) ? $clog2(c_NE) : 1;
    localparam int c_CW    = $clog2(N_SLICES + 2);
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(c_NE - 1);
    localparam logic [15:0]     c_CNT_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_L1    = 3'd1,
        S_L2    = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_inv_start;
    logic [ADDR_WIDTH-1:0] r_inv_end;
    logic [c_IW-1:0]       r_rd_idx;
    logic [c_IW-1:0]       w_rd_idx_nxt;
    logic                  r_cmp_vld;
    logic [c_IW-1:0]       r_cmp_idx;
    logic [15:0]           r_clr_cnt;
    logic                  w_xfer;
    logic                  w_rd_en;
    logic [c_IW-1:0]       w_rd_addr;
    logic [N_SLICES-1:0]   w_l1_hit;
    logic [N_SLICES-1:0]   w_l1_clr;
    logic                  w_l2_clr;
    logic [c_CW-1:0]       w_inc;
    logic [16:0]           w_cnt_sum;

    assign w_xfer = bus.inv_req_i && (r_state == S_IDLE);

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_state     <= S_IDLE;
            r_inv_start <= '0;
            r_inv_end   <= '0;
            r_rd_idx    <= '0;
            r_cmp_vld   <= 1'b0;
            r_cmp_idx   <= '0;
            r_clr_cnt   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_idx  <= w_rd_idx_nxt;
            r_cmp_vld <= w_rd_en;
            r_cmp_idx <= w_rd_addr;
            r_clr_cnt <= w_cnt_sum[16] ? c_CNT_MAX : w_cnt_sum[15:0];
            if (w_xfer) begin
                r_inv_start <= bus.inv_start_i;
                r_inv_end   <= bus.inv_end_i;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_idx_nxt = r_rd_idx;
        w_rd_en      = 1'b0;
        w_rd_addr    = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.inv_req_i) begin
                    w_state_nxt = S_L1;
                end
            end
            S_L1: begin
                if (EN_L2 != 0) begin
                    w_rd_en      = 1'b1;
                    w_rd_addr    = '0;
                    w_rd_idx_nxt = c_IW'(1);
                    w_state_nxt  = (c_NE == 1) ? S_DRAIN : S_L2;
                end else begin
                    w_state_nxt  = S_DONE;
                end
            end
            S_L2: begin
                w_rd_en      = 1'b1;
                w_rd_addr    = r_rd_idx;
                w_rd_idx_nxt = r_rd_idx + c_IW'(1);
                if (r_rd_idx == c_LAST_IDX) begin
                    w_rd_idx_nxt = '0;
                    w_state_nxt  = S_DRAIN;
                end
            end
            // Last read's data is compared here; nothing new is issued.
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Inclusive interval overlap of each slice against the latched range.
    for (genvar g = 0; g < N_SLICES; g++) begin : g_slice
        assign w_l1_hit[g] = bus.l1_en_i[g]
            && (bus.l1_start_i[g*ADDR_WIDTH +: ADDR_WIDTH] <= r_inv_end)
            && (bus.l1_end_i[g*ADDR_WIDTH +: ADDR_WIDTH]   >= r_inv_start);
    end

    assign w_l1_clr = (r_state == S_L1) ? w_l1_hit : '0;

    if (EN_L2 != 0) begin : g_l2
        logic [ADDR_WIDTH-1:0] w_pg_lo;
        logic [ADDR_WIDTH-1:0] w_pg_hi;
        assign w_pg_lo  = {bus.l2_rd_vpn_i, {PAGE_SHIFT{1'b0}}};
        assign w_pg_hi  = {bus.l2_rd_vpn_i, {PAGE_SHIFT{1'b1}}};
        assign w_l2_clr = r_cmp_vld && bus.l2_rd_valid_i
                          && (w_pg_lo <= r_inv_end) && (w_pg_hi >= r_inv_start);
    end else begin : g_no_l2
        assign w_l2_clr = 1'b0;
    end

    always_comb begin
        w_inc = c_CW'(w_l2_clr);
        for (int i = 0; i < N_SLICES; i++) begin
            w_inc = w_inc + c_CW'(w_l1_clr[i]);
        end
    end

    assign w_cnt_sum = {1'b0, r_clr_cnt} + 17'(w_inc);

    assign bus.inv_ready_o   = (r_state == S_IDLE);
    assign bus.busy_o        = (r_state != S_IDLE);
    assign bus.done_o        = (r_state == S_DONE);
    assign bus.l1_clr_o      = w_l1_clr;
    assign bus.l2_rd_en_o    = w_rd_en;
    assign bus.l2_rd_addr_o  = w_rd_addr;
    assign bus.l2_clr_o      = w_l2_clr;
    assign bus.l2_clr_addr_o = w_l2_clr ? r_cmp_idx : '0;
    assign bus.clr_cnt_o     = r_clr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rab_inv_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rab_inv_engine
// Brief    : Randomized and directed sweeps against an interval-overlap model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rab_inv_engine;
    localparam int AW = 32;
    localparam int NS = 4;
    localparam int NE = 8;
    localparam int IW = 3;
    localparam int PS = 12;
    localparam int VW = AW - PS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req0, req1;
    logic [AW-1:0] inv_s, inv_e;
    logic [AW-1:0] sl_s [NS];
    logic [AW-1:0] sl_e [NS];
    logic [NS-1:0] sl_en;
    logic [VW-1:0] mem_vpn [NE];
    logic          mem_vld [NE];
    logic [VW-1:0] rd_vpn;
    logic          rd_vld;
    logic [NS*AW-1:0] l1_s_pk, l1_e_pk;

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    rab_inv_engine_if #(.ADDR_WIDTH(AW), .N_SLICES(NS), .IW(IW), .PAGE_SHIFT(PS)) bus0 ();
    rab_inv_engine_if #(.ADDR_WIDTH(AW), .N_SLICES(NS), .IW(IW), .PAGE_SHIFT(PS)) bus1 ();

    rab_inv_engine #(.ADDR_WIDTH(AW), .N_SLICES(NS), .N_L2_SETS(4), .N_L2_SET_ENTRIES(2),
                     .EN_L2(0), .PAGE_SHIFT(PS))
        u_dut0 (.Clk_CI(clk), .Rst_RBI(rst_n), .bus(bus0));
    rab_inv_engine #(.ADDR_WIDTH(AW), .N_SLICES(NS), .N_L2_SETS(4), .N_L2_SET_ENTRIES(2),
                     .EN_L2(1), .PAGE_SHIFT(PS))
        u_dut1 (.Clk_CI(clk), .Rst_RBI(rst_n), .bus(bus1));

    always_comb begin
        l1_s_pk = '0;
        l1_e_pk = '0;
        for (int i = 0; i < NS; i++) begin
            l1_s_pk[i*AW +: AW] = sl_s[i];
            l1_e_pk[i*AW +: AW] = sl_e[i];
        end
    end

    assign bus0.inv_req_i     = req0;
    assign bus0.inv_start_i   = inv_s;
    assign bus0.inv_end_i     = inv_e;
    assign bus0.l1_start_i    = l1_s_pk;
    assign bus0.l1_end_i      = l1_e_pk;
    assign bus0.l1_en_i       = sl_en;
    assign bus0.l2_rd_vpn_i   = '0;
    assign bus0.l2_rd_valid_i = 1'b0;
    assign bus1.inv_req_i     = req1;
    assign bus1.inv_start_i   = inv_s;
    assign bus1.inv_end_i     = inv_e;
    assign bus1.l1_start_i    = l1_s_pk;
    assign bus1.l1_end_i      = l1_e_pk;
    assign bus1.l1_en_i       = sl_en;
    assign bus1.l2_rd_vpn_i   = rd_vpn;
    assign bus1.l2_rd_valid_i = rd_vld;

    // L2 array model: synchronous read, data one cycle after the request.
    always @(posedge clk) begin
        rd_vpn <= mem_vpn[bus1.l2_rd_addr_o];
        rd_vld <= bus1.l2_rd_en_o && mem_vld[bus1.l2_rd_addr_o];
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // One request to both engines; when hold is set, req1 is reasserted from
    // cycle 2 and left high so the next call's transfer is the held request.
    task automatic sweep(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit hold);
        logic [NS-1:0] x_l1;
        bit            x_l2 [NE];
        int            n_l2;
        int            w;
        longint        ls, le, lo, hi;
        bit            hit;
        w = 0;
        while (bus1.inv_ready_o !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", bus1.inv_ready_o, 1'b1);
        ls = s;
        le = e;
        x_l1 = '0;
        for (int i = 0; i < NS; i++) begin
            lo = sl_s[i];
            hi = sl_e[i];
            x_l1[i] = sl_en[i] && (lo <= le) && (hi >= ls);
        end
        n_l2 = 0;
        for (int i = 0; i < NE; i++) begin
            lo = mem_vpn[i];
            lo = lo * 4096;
            hi = lo + 4095;
            x_l2[i] = mem_vld[i] && (lo <= le) && (hi >= ls);
            n_l2 += x_l2[i] ? 1 : 0;
        end
        inv_s = s;
        inv_e = e;
        req0  = 1'b1;
        req1  = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        exp_cnt0 = sat(exp_cnt0 + $countones(x_l1));
        exp_cnt1 = sat(exp_cnt1 + $countones(x_l1) + n_l2);
        for (int k = 1; k <= NE + 3; k++) begin
            @(negedge clk);
            hit = (k >= 2 && k <= NE + 1) ? x_l2[k-2] : 1'b0;
            check("l1_clr", bus1.l1_clr_o, (k == 1) ? x_l1 : '0);
            check("l2_rd_en", bus1.l2_rd_en_o, (k <= NE) ? 1 : 0);
            if (k <= NE) check("l2_rd_addr", bus1.l2_rd_addr_o, k - 1);
            check("l2_clr", bus1.l2_clr_o, hit);
            check("l2_clr_addr", bus1.l2_clr_addr_o, hit ? k - 2 : 0);
            check("done", bus1.done_o, (k == NE + 2) ? 1 : 0);
            check("busy", bus1.busy_o, (k <= NE + 2) ? 1 : 0);
            check("ready", bus1.inv_ready_o, (k == NE + 3) ? 1 : 0);
            if (k <= 3) begin
                check("nol2_l1_clr", bus0.l1_clr_o, (k == 1) ? x_l1 : '0);
                check("nol2_done", bus0.done_o, (k == 2) ? 1 : 0);
                check("nol2_ready", bus0.inv_ready_o, (k == 3) ? 1 : 0);
                check("nol2_rd_en", bus0.l2_rd_en_o, 0);
            end
            if (k == 3) check("nol2_cnt", bus0.clr_cnt_o, exp_cnt0);
            if (k == NE + 3) check("clr_cnt", bus1.clr_cnt_o, exp_cnt1);
            if (k == 2 && hold) req1 = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {bus1.inv_ready_o, bus0.inv_ready_o}, 2'b11);
        check({tag, "_busy"}, {bus1.busy_o, bus0.busy_o}, 2'b00);
        check({tag, "_done"}, {bus1.done_o, bus0.done_o}, 2'b00);
        check({tag, "_l1_clr"}, {bus1.l1_clr_o, bus0.l1_clr_o}, 0);
        check({tag, "_l2"}, {bus1.l2_rd_en_o, bus1.l2_rd_addr_o, bus1.l2_clr_o, bus1.l2_clr_addr_o}, 0);
        check({tag, "_cnt"}, {bus1.clr_cnt_o, bus0.clr_cnt_o}, 0);
    endtask

    initial begin
        req0  = 1'b0;
        req1  = 1'b0;
        inv_s = '0;
        inv_e = '0;
        sl_en = '0;
        for (int i = 0; i < NS; i++) begin
            sl_s[i] = AW'(i * 32'h1000);
            sl_e[i] = AW'(i * 32'h1000 + 32'hFFF);
        end
        for (int i = 0; i < NE; i++) begin
            mem_vpn[i] = VW'(i + 4);
            mem_vld[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single slice hit, no L2 entries valid.
        sl_en = 4'hF;
        sweep(32'h1000, 32'h1FFF, 1'b0);
        check("dir_cnt1", bus0.clr_cnt_o, 1);

        // Two L2 pages inside the range, slices disabled.
        sl_en = '0;
        for (int i = 0; i < NE; i++) mem_vld[i] = 1'b1;
        sweep(32'h5000, 32'h6FFF, 1'b0);

        // Inverted range: full timing, no clears.
        sl_en = 4'hF;
        sweep(32'h2000, 32'h1000, 1'b0);

        // Held request accepted only back in idle.
        sweep(32'h0, 32'h2FFF, 1'b1);
        sweep(32'h3000, 32'h7FFF, 1'b0);

        for (int n = 0; n < 14; n++) begin
            for (int i = 0; i < NS; i++) begin
                sl_s[i] = AW'($urandom_range(0, 15) * 4096 + $urandom_range(0, 4095));
                sl_e[i] = sl_s[i] + AW'($urandom_range(0, 32'h3000));
            end
            sl_en = NS'($urandom);
            for (int i = 0; i < NE; i++) begin
                mem_vpn[i] = VW'($urandom_range(0, 15));
                mem_vld[i] = ($urandom_range(0, 3) != 0);
            end
            inv_s = AW'($urandom_range(0, 32'h10000));
            if ($urandom_range(0, 3) == 0) inv_e = AW'($urandom_range(0, 32'h10000));
            else                          inv_e = inv_s + AW'($urandom_range(0, 32'h4000));
            sweep(inv_s, inv_e, 1'b0);
        end

        // Reset in the middle of a full-range sweep.
        for (int i = 0; i < NS; i++) begin
            sl_s[i] = AW'(i * 32'h1000);
            sl_e[i] = AW'(i * 32'h1000 + 32'hFFF);
        end
        sl_en = 4'hF;
        for (int i = 0; i < NE; i++) begin
            mem_vpn[i] = VW'(i + 4);
            mem_vld[i] = 1'b1;
        end
        inv_s = '0;
        inv_e = '1;
        req0  = 1'b1;
        req1  = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check("post_rst_quiet", {bus1.done_o, bus1.l2_clr_o, bus1.l1_clr_o, bus0.done_o},
                  0);
        end
        check("post_rst_ready", bus1.inv_ready_o, 1'b1);

        // Full address range clears every slice and every valid entry.
        sweep(32'h0, 32'hFFFF_FFFF, 1'b0);
        check("full_cnt", bus1.clr_cnt_o, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/rab_inv_engine.md
RAB_INV_ENGINE -- requirements
Module: rab_inv_engine

Interface
REQ-001 Parameter ADDR_WIDTH, 32, virtual address width.
REQ-002 Parameter N_SLICES, 16, number of L1 slices swept.
REQ-003 Parameter N_L2_SETS, 32, L2 TLB sets; N_L2_SET_ENTRIES, 32, entries per set; NE = N_L2_SETS*N_L2_SET_ENTRIES; IW = $clog2(NE).
REQ-004 Parameter EN_L2, 1, 0 omits the L2 sweep; PAGE_SHIFT, 12, page offset bits.
REQ-005 Clk_CI  in  1  sole clock, rising edge; Rst_RBI  in  1  reset, asynchronous, active-low.
REQ-006 inv_req_i  in  1, inv_ready_o  out  1  request handshake; transfer when both high on a rising edge.
REQ-007 inv_start_i, inv_end_i  in  ADDR_WIDTH  inclusive invalidation range, sampled on transfer.
REQ-008 l1_start_i, l1_end_i  in  N_SLICES*ADDR_WIDTH  slice ranges; l1_en_i  in  N_SLICES  slice enables.
REQ-009 l1_clr_o  out  N_SLICES  one-cycle pulses clearing slice enables.
REQ-010 l2_rd_en_o  out  1, l2_rd_addr_o  out  IW  L2 read port; l2_rd_vpn_i  in  ADDR_WIDTH-PAGE_SHIFT, l2_rd_valid_i  in  1  read data, one cycle after l2_rd_en_o.
REQ-011 l2_clr_o  out  1, l2_clr_addr_o  out  IW  clear valid bit of one L2 entry.
REQ-012 busy_o  out  1  sweep active; lookups must stall while high. done_o  out  1  one-cycle completion pulse.
REQ-013 clr_cnt_o  out  16  cumulative cleared-entry count, saturating at 16'hFFFF.

Function
REQ-014 FSM states IDLE, L1, L2, DRAIN, DONE; IDLE is the only state with inv_ready_o=1.
REQ-015 IDLE -> L1 on transfer; busy_o high from the next cycle until after done_o.
REQ-016 L1 (one cycle): l1_clr_o[i]=1 iff l1_en_i[i] && l1_start[i] <= inv_end && l1_end[i] >= inv_start, all slices compared in parallel.
REQ-017 In L1 with EN_L2=1: l2_rd_en_o=1, l2_rd_addr_o=0; next state L2. With EN_L2=0: next state DONE.
REQ-018 L2: one read per cycle, index incrementing by 1 up to NE-1; after issuing NE-1 go to DRAIN (one cycle), then DONE.
REQ-019 Compare stage, cycle after each read: match iff l2_rd_valid_i && {vpn,PAGE_SHIFT'b0} <= inv_end && {vpn,PAGE_SHIFT'b1...1} >= inv_start; on match l2_clr_o=1, l2_clr_addr_o = registered read index.
REQ-020 Latency, transfer at cycle 0: L1 clears at cycle 1; reads cycles 1..NE; L2 clears cycles 2..NE+1; done_o at NE+2 (EN_L2=0: cycle 2); inv_ready_o high again at NE+3 (EN_L2=0: cycle 3).
REQ-021 DONE -> IDLE unconditionally; a request held high during a sweep is accepted only in IDLE, with no loss or duplication.
REQ-022 inv_start > inv_end: accepted, full sweep timing, zero clears, done_o still pulses.
REQ-023 Range compares are unsigned; the range ADDR_WIDTH'h0..all-ones clears every enabled slice and every valid L2 entry.
REQ-024 clr_cnt_o increments by popcount(l1_clr_o) + l2_clr_o each cycle, saturating; it never wraps.
REQ-025 Slice or L2 contents changing mid-sweep: evaluation uses the values present in the compare cycle only; no rescan.

Reset
REQ-026 Rst_RBI low asynchronously forces state IDLE, inv_ready_o=1, busy_o=0, done_o=0, l1_clr_o=0, l2_rd_en_o=0, l2_clr_o=0, l2 addresses=0, clr_cnt_o=0.
REQ-027 Reset mid-sweep abandons the sweep: no further clear pulses and no done_o for that request.

Verification (N_SLICES=4, N_L2_SETS=4, N_L2_SET_ENTRIES=2, PAGE_SHIFT=12, NE=8)
REQ-028 Slices [0x0000-0x0FFF],[0x1000-0x1FFF],[0x2000-0x2FFF],[0x3000-0x3FFF] all enabled; range 0x1000-0x1FFF, EN_L2=0 -> l1_clr_o=4'b0010 at cycle 1, done_o at cycle 2, clr_cnt_o=1.
REQ-029 L2 entries 0..7 valid, vpn=index+4; range 0x5000-0x6FFF -> l2_clr_o at cycles 3 and 4 with addresses 1 and 2, done_o at cycle 10.
REQ-030 Range 0x2000-0x1000 -> no clear pulses, done_o at cycle 10, clr_cnt_o unchanged.
REQ-031 Second inv_req_i held high from cycle 2 -> accepted at cycle 11, second done_o at cycle 21.
REQ-032 Rst_RBI low at cycle 5 of a full-range sweep -> outputs at reset values immediately, no done_o, inv_ready_o=1.
REQ-033 Range 0x0-0xFFFFFFFF with all 4 slices and 8 L2 entries valid -> clr_cnt_o=12 after done_o.
